// File: rtl/axil_regmap_slave.sv
// -----------------------------------------------------------------------------
// axil_regmap_slave
//
// AXI4-Lite slave exposing NUM_REGS read/write control registers followed by
// one read-only status register. Word index = addr[ADDR_W-1:2]; the low two
// address bits are ignored, so unaligned accesses align down.
//   index 0..NUM_REGS-1 : control registers (RW, byte strobes honoured)
//   index NUM_REGS      : status register (RO, returns status_in; writes SLVERR)
//   anything else       : unmapped (reads 0 with SLVERR, writes SLVERR)
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   axil_aw*/w*/b*      AXI-Lite write address, write data, write response
//   axil_ar*/r*         AXI-Lite read address, read data
//   ctrl_regs           flattened control registers, reg i at [i*DATA_W +: DATA_W]
//   ctrl_wr_pulse       one-cycle pulse per control register when it is written
//   status_in           value returned by the status register
// -----------------------------------------------------------------------------
module axil_regmap_slave #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int STRB_W   = DATA_W / 8,
    parameter int NUM_REGS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          axil_awaddr,
    input  logic [2:0]                 axil_awprot,
    input  logic                       axil_awvalid,
    output logic                       axil_awready,
    input  logic [DATA_W-1:0]          axil_wdata,
    input  logic [STRB_W-1:0]          axil_wstrb,
    input  logic                       axil_wvalid,
    output logic                       axil_wready,
    output logic [1:0]                 axil_bresp,
    output logic                       axil_bvalid,
    input  logic                       axil_bready,
    input  logic [ADDR_W-1:0]          axil_araddr,
    input  logic [2:0]                 axil_arprot,
    input  logic                       axil_arvalid,
    output logic                       axil_arready,
    output logic [DATA_W-1:0]          axil_rdata,
    output logic [1:0]                 axil_rresp,
    output logic                       axil_rvalid,
    input  logic                       axil_rready,
    output logic [NUM_REGS*DATA_W-1:0] ctrl_regs,
    output logic [NUM_REGS-1:0]        ctrl_wr_pulse,
    input  logic [DATA_W-1:0]          status_in
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_RESP}         rstate_t;

    // Write-side state
    wstate_t                   wstate_q, wstate_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic [IDX_W-1:0]          aw_idx_q, aw_idx_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;
    logic [STRB_W-1:0]         wstrb_q, wstrb_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [NUM_REGS*DATA_W-1:0] ctrl_q, ctrl_d;
    logic [NUM_REGS-1:0]       wr_pulse;

    // Read-side state
    rstate_t                   rstate_q, rstate_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic [DATA_W-1:0]         rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [IDX_W-1:0]          ar_idx;

    // Protection bits and the byte offset carry no meaning for this block.
    logic unused_inputs;
    assign unused_inputs = ^{axil_awprot, axil_arprot, axil_awaddr[1:0], axil_araddr[1:0]};

    assign ar_idx = axil_araddr[ADDR_W-1:2];

    // Write channel: AW and W are captured independently; once both are held
    // the register update happens in a single W_EXEC cycle, after which the
    // response is held in W_RESP until the master accepts it.
    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        wr_pulse  = '0;

        case (wstate_q)
            W_IDLE: begin
                if (axil_awvalid && awready_q) begin
                    aw_idx_d  = axil_awaddr[ADDR_W-1:2];
                    awready_d = 1'b0;
                end
                if (axil_wvalid && wready_q) begin
                    wdata_d  = axil_wdata;
                    wstrb_d  = axil_wstrb;
                    wready_d = 1'b0;
                end
                // A low ready after this edge means that channel is held.
                if (!awready_d && !wready_d) begin
                    wstate_d = W_EXEC;
                end
            end
            W_EXEC: begin
                // Status and unmapped indices fall through as SLVERR.
                bresp_d = RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (aw_idx_q == IDX_W'(i)) begin
                        wr_pulse[i] = 1'b1;
                        bresp_d     = RESP_OKAY;
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wstrb_q[b]) begin
                                ctrl_d[i*DATA_W + b*8 +: 8] = wdata_q[b*8 +: 8];
                            end
                        end
                    end
                end
                bvalid_d = 1'b1;
                wstate_d = W_RESP;
            end
            W_RESP: begin
                if (axil_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: begin
                wstate_d = W_IDLE;
            end
        endcase
    end

    // Read channel: the response is registered on the same edge the address
    // is accepted, so a read that coincides with a W_EXEC update of the same
    // register sees the pre-update contents.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (rstate_q)
            R_IDLE: begin
                if (axil_arvalid && arready_q) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (ar_idx == IDX_W'(i)) begin
                            rdata_d = ctrl_q[i*DATA_W +: DATA_W];
                            rresp_d = RESP_OKAY;
                        end
                    end
                    if (ar_idx == IDX_W'(NUM_REGS)) begin
                        rdata_d = status_in;
                        rresp_d = RESP_OKAY;
                    end
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    rstate_d  = R_RESP;
                end
            end
            R_RESP: begin
                if (axil_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
            default: begin
                rstate_d = R_IDLE;
            end
        endcase
    end

    // State registers for both channels; reset abandons any transaction in
    // flight without issuing a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            ctrl_q    <= '0;
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            ctrl_q    <= ctrl_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign axil_awready  = awready_q;
    assign axil_wready   = wready_q;
    assign axil_bvalid   = bvalid_q;
    assign axil_bresp    = bresp_q;
    assign axil_arready  = arready_q;
    assign axil_rvalid   = rvalid_q;
    assign axil_rdata    = rdata_q;
    assign axil_rresp    = rresp_q;
    assign ctrl_regs     = ctrl_q;
    assign ctrl_wr_pulse = wr_pulse;

endmodule

// File: tb/tb_axil_regmap_slave.sv
// -----------------------------------------------------------------------------
// tb_axil_regmap_slave
//
// Directed bench for axil_regmap_slave. Stimulus tasks push the expected
// B/R responses into queues; an independent monitor pops and compares them
// whenever a response handshake is seen. Register contents, write pulses and
// ready/valid timing are checked directly against hand-computed values.
// -----------------------------------------------------------------------------
module tb_axil_regmap_slave;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int STRB_W   = 4;
    localparam int NUM_REGS = 8;
    localparam int CW       = NUM_REGS * DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] axil_awaddr;
    logic [2:0]        axil_awprot;
    logic              axil_awvalid;
    logic              axil_awready;
    logic [DATA_W-1:0] axil_wdata;
    logic [STRB_W-1:0] axil_wstrb;
    logic              axil_wvalid;
    logic              axil_wready;
    logic [1:0]        axil_bresp;
    logic              axil_bvalid;
    logic              axil_bready;
    logic [ADDR_W-1:0] axil_araddr;
    logic [2:0]        axil_arprot;
    logic              axil_arvalid;
    logic              axil_arready;
    logic [DATA_W-1:0] axil_rdata;
    logic [1:0]        axil_rresp;
    logic              axil_rvalid;
    logic              axil_rready;
    logic [CW-1:0]     ctrl_regs;
    logic [NUM_REGS-1:0] ctrl_wr_pulse;
    logic [DATA_W-1:0] status_in;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    int          pulse_cnt[NUM_REGS] = '{default: 0};
    logic [CW-1:0] exp_ctrl;

    always #5 clk = ~clk;

    axil_regmap_slave #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .NUM_REGS(NUM_REGS)
    ) dut (
        .clk(clk), .rst(rst),
        .axil_awaddr(axil_awaddr), .axil_awprot(axil_awprot),
        .axil_awvalid(axil_awvalid), .axil_awready(axil_awready),
        .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb),
        .axil_wvalid(axil_wvalid), .axil_wready(axil_wready),
        .axil_bresp(axil_bresp), .axil_bvalid(axil_bvalid), .axil_bready(axil_bready),
        .axil_araddr(axil_araddr), .axil_arprot(axil_arprot),
        .axil_arvalid(axil_arvalid), .axil_arready(axil_arready),
        .axil_rdata(axil_rdata), .axil_rresp(axil_rresp),
        .axil_rvalid(axil_rvalid), .axil_rready(axil_rready),
        .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse), .status_in(status_in)
    );

    task automatic checkOutput(input string name, input logic [CW-1:0] act,
                               input logic [CW-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: timed out waiting for handshake", name);
    endtask

    // Response monitor: compares every accepted B/R beat with the queue head.
    always @(negedge clk) begin
        if (!rst && axil_bvalid && axil_bready) begin
            if (bq.size() == 0) begin
                timeoutFail("bresp_unexpected");
            end else begin
                checkOutput("bresp", CW'(axil_bresp), CW'(bq.pop_front()));
            end
        end
        if (!rst && axil_rvalid && axil_rready) begin
            if (rq.size() == 0) begin
                timeoutFail("rresp_unexpected");
            end else begin
                logic [33:0] e;
                e = rq.pop_front();
                checkOutput("rdata", CW'(axil_rdata), CW'(e[31:0]));
                checkOutput("rresp", CW'(axil_rresp), CW'(e[33:32]));
            end
        end
    end

    // Counts write-pulse cycles per register.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ctrl_wr_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
        end
    end

    function automatic int sumPulses();
        int s = 0;
        for (int i = 0; i < NUM_REGS; i++) s += pulse_cnt[i];
        return s;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs, done = 0;
        bq.push_back(exp_resp);
        axil_awaddr  = addr;
        axil_wdata   = data;
        axil_wstrb   = strb;
        axil_awvalid = 1'b1;
        axil_wvalid  = 1'b1;
        axil_bready  = 1'b1;
        for (int k = 0; k < 20 && !(aw_done && w_done); k++) begin
            @(negedge clk);
            aw_hs = axil_awvalid && axil_awready;
            w_hs  = axil_wvalid && axil_wready;
            cyc();
            if (aw_hs) begin axil_awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin axil_wvalid  = 1'b0; w_done  = 1; end
        end
        if (!(aw_done && w_done)) timeoutFail("aw_w_accept");
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (axil_bvalid) done = 1;
            cyc();
        end
        if (!done) timeoutFail("bvalid_wait");
        axil_bready  = 1'b0;
        axil_awvalid = 1'b0;
        axil_wvalid  = 1'b0;
    endtask

    task automatic axiRead(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
        bit ar_done = 0, ar_hs, done = 0;
        rq.push_back({exp_resp, exp_data});
        axil_araddr  = addr;
        axil_arvalid = 1'b1;
        axil_rready  = 1'b1;
        for (int k = 0; k < 20 && !ar_done; k++) begin
            @(negedge clk);
            ar_hs = axil_arvalid && axil_arready;
            cyc();
            if (ar_hs) begin axil_arvalid = 1'b0; ar_done = 1; end
        end
        if (!ar_done) timeoutFail("ar_accept");
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (axil_rvalid) done = 1;
            cyc();
        end
        if (!done) timeoutFail("rvalid_wait");
        axil_rready  = 1'b0;
        axil_arvalid = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_awready"}, CW'(axil_awready), CW'(1'b1));
        checkOutput({tag, "_wready"},  CW'(axil_wready),  CW'(1'b1));
        checkOutput({tag, "_arready"}, CW'(axil_arready), CW'(1'b1));
        checkOutput({tag, "_bvalid"},  CW'(axil_bvalid),  CW'(1'b0));
        checkOutput({tag, "_rvalid"},  CW'(axil_rvalid),  CW'(1'b0));
    endtask

    task automatic applyStimulus();
        int p_before, tot_before;

        rst = 1'b1;
        axil_awaddr = '0; axil_awprot = '0; axil_awvalid = 1'b0;
        axil_wdata = '0; axil_wstrb = '0; axil_wvalid = 1'b0; axil_bready = 1'b0;
        axil_araddr = '0; axil_arprot = '0; axil_arvalid = 1'b0; axil_rready = 1'b0;
        status_in = '0;
        exp_ctrl = '0;
        cyc(); cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        checkIdle("reset");
        checkOutput("reset_bresp", CW'(axil_bresp), CW'(2'b00));
        checkOutput("reset_rresp", CW'(axil_rresp), CW'(2'b00));
        checkOutput("reset_rdata", CW'(axil_rdata), CW'(32'h0));
        checkOutput("reset_ctrl", ctrl_regs, exp_ctrl);
        checkOutput("reset_pulse", CW'(ctrl_wr_pulse), CW'(8'h00));
        cyc();

        // Full-word write then read back
        p_before = pulse_cnt[1];
        tot_before = sumPulses();
        axiWrite(32'h04, 32'hDEADBEEF, 4'hF, 2'b00);
        exp_ctrl[1*32 +: 32] = 32'hDEADBEEF;
        checkOutput("t1_ctrl", ctrl_regs, exp_ctrl);
        checkOutput("t1_pulse1_cycles", CW'(pulse_cnt[1] - p_before), CW'(1));
        checkOutput("t1_pulse_total", CW'(sumPulses() - tot_before), CW'(1));
        axiRead(32'h04, 32'hDEADBEEF, 2'b00);

        // Byte-strobed partial write
        axiWrite(32'h04, 32'h11223344, 4'b0101, 2'b00);
        exp_ctrl[1*32 +: 32] = 32'hDE22BE44;
        checkOutput("t2_ctrl", ctrl_regs, exp_ctrl);
        axiRead(32'h04, 32'hDE22BE44, 2'b00);

        // Unaligned address aligns down; top control register
        axiWrite(32'h0B, 32'h12345678, 4'hF, 2'b00);
        exp_ctrl[2*32 +: 32] = 32'h12345678;
        axiWrite(32'h1C, 32'hCAFEF00D, 4'hF, 2'b00);
        exp_ctrl[7*32 +: 32] = 32'hCAFEF00D;
        checkOutput("unaligned_ctrl", ctrl_regs, exp_ctrl);
        axiRead(32'h08, 32'h12345678, 2'b00);
        axiRead(32'h1F, 32'hCAFEF00D, 2'b00);

        // Zero strobe still pulses but changes nothing
        p_before = pulse_cnt[2];
        axiWrite(32'h08, 32'hFFFFFFFF, 4'h0, 2'b00);
        checkOutput("zero_strb_ctrl", ctrl_regs, exp_ctrl);
        checkOutput("zero_strb_pulse", CW'(pulse_cnt[2] - p_before), CW'(1));

        // Status register: readable, write rejected
        status_in = 32'hA5A50001;
        axiRead(32'h20, 32'hA5A50001, 2'b00);
        tot_before = sumPulses();
        axiWrite(32'h20, 32'hFFFFFFFF, 4'hF, 2'b10);
        checkOutput("t3_ctrl", ctrl_regs, exp_ctrl);
        checkOutput("t3_no_pulse", CW'(sumPulses() - tot_before), CW'(0));

        // Unmapped index
        axiRead(32'h100, 32'h0, 2'b10);
        tot_before = sumPulses();
        axiWrite(32'h100, 32'hFFFFFFFF, 4'hF, 2'b10);
        checkOutput("t4_ctrl", ctrl_regs, exp_ctrl);
        checkOutput("t4_no_pulse", CW'(sumPulses() - tot_before), CW'(0));

        // AW alone, W three cycles later, response back-pressured
        bq.push_back(2'b00);
        axil_awaddr  = 32'h0C;
        axil_awvalid = 1'b1;
        axil_bready  = 1'b0;
        cyc();
        axil_awvalid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checkOutput("t5_awready_low", CW'(axil_awready), CW'(1'b0));
            checkOutput("t5_wready_high", CW'(axil_wready), CW'(1'b1));
            cyc();
        end
        axil_wdata  = 32'h0BADF00D;
        axil_wstrb  = 4'hF;
        axil_wvalid = 1'b1;
        @(negedge clk);
        checkOutput("t5_wready_before_w", CW'(axil_wready), CW'(1'b1));
        cyc();
        axil_wvalid = 1'b0;
        @(negedge clk);
        checkOutput("t5_exec_bvalid", CW'(axil_bvalid), CW'(1'b0));
        checkOutput("t5_exec_pulse", CW'(ctrl_wr_pulse), CW'(8'h08));
        checkOutput("t5_exec_wready", CW'(axil_wready), CW'(1'b0));
        cyc();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("t5_bvalid_held", CW'(axil_bvalid), CW'(1'b1));
            checkOutput("t5_bresp_held", CW'(axil_bresp), CW'(2'b00));
            checkOutput("t5_awready_resp", CW'(axil_awready), CW'(1'b0));
            cyc();
        end
        axil_bready = 1'b1;
        cyc();
        axil_bready = 1'b0;
        @(negedge clk);
        checkOutput("t5_bvalid_done", CW'(axil_bvalid), CW'(1'b0));
        checkOutput("t5_awready_back", CW'(axil_awready), CW'(1'b1));
        checkOutput("t5_wready_back", CW'(axil_wready), CW'(1'b1));
        exp_ctrl[3*32 +: 32] = 32'h0BADF00D;
        checkOutput("t5_ctrl", ctrl_regs, exp_ctrl);
        cyc();

        // Reset while both responses are pending
        axil_awaddr = 32'h00; axil_wdata = 32'h00000055; axil_wstrb = 4'hF;
        axil_araddr = 32'h00;
        axil_awvalid = 1'b1; axil_wvalid = 1'b1; axil_arvalid = 1'b1;
        axil_bready = 1'b0; axil_rready = 1'b0;
        cyc();
        axil_awvalid = 1'b0; axil_wvalid = 1'b0; axil_arvalid = 1'b0;
        cyc();
        @(negedge clk);
        checkOutput("t6_rvalid_pending", CW'(axil_rvalid), CW'(1'b1));
        checkOutput("t6_bvalid_pending", CW'(axil_bvalid), CW'(1'b1));
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        exp_ctrl = '0;
        checkIdle("t6_after_reset");
        checkOutput("t6_ctrl", ctrl_regs, exp_ctrl);
        cyc();
        axiWrite(32'h00, 32'h600DCAFE, 4'hF, 2'b00);
        exp_ctrl[0 +: 32] = 32'h600DCAFE;
        checkOutput("t6_ctrl_after", ctrl_regs, exp_ctrl);
        axiRead(32'h00, 32'h600DCAFE, 2'b00);

        cyc(); cyc();
        checkOutput("b_queue_drained", CW'(bq.size()), CW'(0));
        checkOutput("r_queue_drained", CW'(rq.size()), CW'(0));
    endtask

    // Watchdog so the run always ends even if the design stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/axil_regmap_slave.md
Name: axil_regmap_slave

Overview:
AXI4-Lite slave that terminates transactions issued on the axi_lite interface and implements a small memory-mapped register file. It provides NUM_REGS read/write control registers and one read-only status register. It sits directly downstream of the axi_lite bus, which the testbench master tasks drive. Control register contents and per-register write pulses go to the datapath.

Parameters:
ADDR_W, 32, AXI-Lite address width
DATA_W, 32, data width; only 32 is supported
STRB_W, DATA_W/8, write strobe width
NUM_REGS, 8, number of RW control registers (1..64)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
axil_awaddr  in  ADDR_W  write address
axil_awprot  in  3  ignored
axil_awvalid  in  1  write address valid
axil_awready  out  1  write address ready
axil_wdata  in  DATA_W  write data
axil_wstrb  in  STRB_W  byte-lane enables
axil_wvalid  in  1  write data valid
axil_wready  out  1  write data ready
axil_bresp  out  2  write response
axil_bvalid  out  1  write response valid
axil_bready  in  1  write response ready
axil_araddr  in  ADDR_W  read address
axil_arprot  in  3  ignored
axil_arvalid  in  1  read address valid
axil_arready  out  1  read address ready
axil_rdata  out  DATA_W  read data
axil_rresp  out  2  read response
axil_rvalid  out  1  read valid
axil_rready  in  1  read data ready
ctrl_regs  out  NUM_REGS*DATA_W  flattened control registers; reg i occupies bits [i*DATA_W +: DATA_W]
ctrl_wr_pulse  out  NUM_REGS  one-cycle pulse when reg i is written
status_in  in  DATA_W  value returned by the RO status register

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - axil_awready=1, axil_wready=1, axil_arready=1.
  - axil_bvalid=0, axil_rvalid=0, axil_bresp=0, axil_rresp=0, axil_rdata=0.
  - ctrl_regs=0, ctrl_wr_pulse=0.
- Reset mid-transaction drops the transaction; no response is issued.
- Address decode uses addr[ADDR_W-1:2] as the word index; addr[1:0] is ignored, so unaligned addresses align down.
  - Index 0..NUM_REGS-1 selects a control register.
  - Index NUM_REGS selects the status register (RO).
  - Any other index is unmapped.
- Readies are asserted before valid: each ready is high while its channel is idle. The master may pulse valid for one cycle only.
- Write FSM, states W_IDLE, W_EXEC, W_RESP:
  - W_IDLE: AW and W are captured independently when valid&ready.
    - The captured channel's ready drops to 0 on the next edge.
    - The other channel's ready stays 1 until that channel is captured.
    - AW and W in the same cycle is legal and captures both.
  - Once both channels are held, go to W_EXEC. Both readies are 0.
  - W_EXEC (one cycle), for a control register:
    - Update the bytes whose wstrb bit is 1; bytes with strb=0 are unchanged.
    - Pulse ctrl_wr_pulse[i] for this cycle. A pulse fires even when wstrb=0.
    - bresp=2'b00 (OKAY).
  - W_EXEC, for the status register or an unmapped index: no update, no pulse, bresp=2'b10 (SLVERR).
  - Next edge: bvalid=1, go to W_RESP.
  - W_RESP: bvalid and bresp are held until bready=1 is sampled. On that edge bvalid=0, awready=wready=1, return to W_IDLE.
  - Latency: AW and W accepted at edge N, register updated at edge N+1, bvalid high after edge N+1.
- Read FSM, states R_IDLE, R_RESP:
  - R_IDLE: arready=1. On arvalid sampled, at the same edge: register rdata, set rresp, set rvalid=1, arready=0, go to R_RESP.
  - Read data by target:
    - control register: its current value, OKAY.
    - status register: status_in sampled at that edge, OKAY.
    - unmapped: rdata=0, SLVERR.
  - R_RESP: rdata, rresp and rvalid are held stable until rready=1 is sampled. On that edge rvalid=0, arready=1.
- Read and write channels are fully independent and may be active at once.
  - A read sampled on the same edge as a W_EXEC update of the same register returns the old value.
- Only one outstanding transaction per channel.

Test Plan:
1. Write 0xDEADBEEF to 0x04 with wstrb=4'hF, then read 0x04 -> bresp=00; ctrl_regs[63:32]=0xDEADBEEF; ctrl_wr_pulse[1] high exactly 1 cycle; rdata=0xDEADBEEF, rresp=00.
2. After test 1, write 0x11223344 to 0x04 with wstrb=4'b0101 -> reg 1 = 0xDE22BE44, bresp=00.
3. Drive status_in=0xA5A5_0001 and read 4*NUM_REGS (0x20); then write 0xFFFFFFFF to 0x20 -> read returns 0xA5A50001 with OKAY; write gives bresp=10, no ctrl_wr_pulse, ctrl_regs unchanged.
4. Read 0x100 and write 0x100 -> rresp=10 with rdata=0; bresp=10; all registers unchanged.
5. Present AW at cycle 0 and W at cycle 3, with bready held low 5 cycles after bvalid -> awready low from cycle 1 while wready stays high until W is taken; bvalid held 5 cycles with stable bresp; both readies return to 1 after the bready edge.
6. Assert rst while rvalid=1 and bready is pending, then check -> after the reset edge rvalid=0, bvalid=0, all readies=1, ctrl_regs=0; a fresh write/read to 0x00 then completes normally.
